// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with a start/done handshake.
//   Add, sub, shifts, rotates, logic ops and compares finish in one cycle.
//   Multiply (shift-add) and divide (restoring) run one bit per cycle, WIDTH cycles.
//   Optional feature macro: SEQ_ALU_WIDE_RESULT_EN adds result_hi
//   (high product half / remainder).
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
`ifdef SEQ_ALU_WIDE_RESULT_EN
  ,
  output logic [WIDTH-1:0] result_hi
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_ROL  = 4'h6;
  localparam logic [3:0] OP_ROR  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
  localparam logic [3:0] OP_NAND = 4'hC;
  localparam logic [3:0] OP_XNOR = 4'hD;
  localparam logic [3:0] OP_GT   = 4'hE;
  localparam logic [3:0] OP_EQ   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t state, state_next;

  // Shared iteration register: mul keeps {product_hi, multiplier/product_lo},
  // div keeps {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;   // multiplicand or divisor
  logic [CW-1:0]      cnt;

  // Single-cycle datapath, fed straight from the ports so results land in c+1.
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf, alu_dz;
  logic [WIDTH-1:0] alu_hi;

  assign sum_ext  = {1'b0, operand1} + {1'b0, operand2};
  assign diff_ext = {1'b0, operand1} - {1'b0, operand2};

  // Iterative step logic.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next  = {mul_sum, acc[WIDTH-1:1]};
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd};
  // Partial remainder < divisor keeps the difference within a signed WIDTH+1 range.
  assign div_ge    = ~div_diff[WIDTH];
  assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      acc[WIDTH-2:0], div_ge};

  assign busy = (state != ST_IDLE);

  // Single-cycle result and flag generation.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    alu_dz    = 1'b0;
    alu_hi    = '0;
    case (opcode)
      OP_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_ovf   = (operand1[WIDTH-1] == operand2[WIDTH-1]) &&
                    (alu_res[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
        alu_ovf   = (operand1[WIDTH-1] != operand2[WIDTH-1]) &&
                    (alu_res[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_DIV: begin
        // Only completes here when the divisor is zero.
        alu_res = '1;
        alu_dz  = 1'b1;
        alu_hi  = operand1;
      end
      OP_SHL: begin
        alu_res   = {operand1[WIDTH-2:0], 1'b0};
        alu_carry = operand1[WIDTH-1];
      end
      OP_SHR: begin
        alu_res   = {1'b0, operand1[WIDTH-1:1]};
        alu_carry = operand1[0];
      end
      OP_ROL: begin
        alu_res   = {operand1[WIDTH-2:0], operand1[WIDTH-1]};
        alu_carry = operand1[WIDTH-1];
      end
      OP_ROR: begin
        alu_res   = {operand1[0], operand1[WIDTH-1:1]};
        alu_carry = operand1[0];
      end
      OP_AND:  alu_res = operand1 & operand2;
      OP_OR:   alu_res = operand1 | operand2;
      OP_XOR:  alu_res = operand1 ^ operand2;
      OP_NOR:  alu_res = ~(operand1 | operand2);
      OP_NAND: alu_res = ~(operand1 & operand2);
      OP_XNOR: alu_res = ~(operand1 ^ operand2);
      OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, (operand1 > operand2)};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, (operand1 == operand2)};
      default: alu_res = '0;  // OP_MUL is handled by the iterative path
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic: divide by zero never leaves IDLE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start && opcode == OP_MUL)
          state_next = ST_MUL;
        else if (start && opcode == OP_DIV && operand2 != '0)
          state_next = ST_DIV;
      end
      ST_MUL, ST_DIV: begin
        if (cnt == LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath registers, outputs and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      done   <= 1'b0;
      result <= '0;
      flags  <= '0;
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
`ifdef SEQ_ALU_WIDE_RESULT_EN
      result_hi <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (opcode == OP_MUL) begin
              acc  <= {{WIDTH{1'b0}}, operand2};
              opnd <= operand1;
              cnt  <= '0;
            end else if (opcode == OP_DIV && operand2 != '0) begin
              acc  <= {{WIDTH{1'b0}}, operand1};
              opnd <= operand2;
              cnt  <= '0;
            end else begin
              done   <= 1'b1;
              result <= alu_res;
              flags  <= {alu_dz, alu_ovf, alu_carry, (alu_res == '0)};
`ifdef SEQ_ALU_WIDE_RESULT_EN
              result_hi <= alu_hi;
`endif
            end
          end
        end
        ST_MUL: begin
          acc <= mul_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            done   <= 1'b1;
            result <= mul_next[WIDTH-1:0];
            flags  <= {2'b00, (mul_next[2*WIDTH-1:WIDTH] != '0),
                       (mul_next[WIDTH-1:0] == '0)};
`ifdef SEQ_ALU_WIDE_RESULT_EN
            result_hi <= mul_next[2*WIDTH-1:WIDTH];
`endif
          end
        end
        ST_DIV: begin
          acc <= div_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            done   <= 1'b1;
            result <= div_next[WIDTH-1:0];
            flags  <= {3'b000, (div_next[WIDTH-1:0] == '0)};
`ifdef SEQ_ALU_WIDE_RESULT_EN
            result_hi <= div_next[2*WIDTH-1:WIDTH];
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifndef SEQ_ALU_WIDE_RESULT_EN
  // High product half / remainder are not exported in this build.
  logic unused_hi;
  assign unused_hi = ^alu_hi;
`endif

endmodule
